// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the Pong game controller.
//   state_t     : top-level game FSM states (encoding is visible on the
//                 controller's `state` output)
//   RGB_*       : background colour per game phase
//   BALL_X0/Y0  : centred ball position, PADDLE_Y0 : centred paddle position
//   in_rect()   : half-open rectangle hit test used by the pixel path
//   state_rgb() : background colour lookup for a game state
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam logic [11:0] RGB_IDLE  = 12'h004;
    localparam logic [11:0] RGB_FIELD = 12'h000;
    localparam logic [11:0] RGB_POINT = 12'h400;
    localparam logic [11:0] RGB_OVER  = 12'h040;

    localparam logic [9:0] BALL_X0   = 10'd316;
    localparam logic [9:0] BALL_Y0   = 10'd236;
    localparam logic [9:0] PADDLE_Y0 = 10'd208;

    // [left, left+w) x [top, top+h); 11-bit so left+w cannot wrap
    function automatic logic in_rect(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] left, input logic [10:0] top,
                                     input logic [10:0] w, input logic [10:0] h);
        return (px >= left) && (px < left + w) && (py >= top) && (py < top + h);
    endfunction

    function automatic logic [11:0] state_rgb(input state_t s);
        case (s)
            ST_IDLE:     return RGB_IDLE;
            ST_POINT:    return RGB_POINT;
            ST_GAMEOVER: return RGB_OVER;
            default:     return RGB_FIELD;
        endcase
    endfunction

endpackage

// File: rtl/pong_game_ctrl_vsync_tick.sv
// ---------------------------------------------------------------------------
// vsync_tick
// Brings the VGA vertical sync into the clk domain and marks its falling edge.
//   clk   in  : pixel clock
//   rst   in  : synchronous active-high reset
//   vs_in in  : VS, asynchronous to clk
//   tick  out : one-cycle pulse, 3 clk cycles after the VS falling edge
// ---------------------------------------------------------------------------
module vsync_tick (
    input  logic clk,
    input  logic rst,
    input  logic vs_in,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic tick_q,  tick_d;

    always_comb begin
        sync1_d = vs_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_d  = prev_q & ~sync2_q;
    end

    // Flops clear to 0 so a VS already high at reset release gives no tick
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Frame-synchronous Pong controller: ball/paddle/score state stepped once per
// frame on the VS tick, plus the registered foreground/background colour path.
//   clk, rst               : pixel clock, synchronous active-high reset
//   vs_in                  : VGA VS (asynchronous)
//   x, y                   : current VGA pixel coordinate
//   start                  : start button (level, sampled on tick)
//   up_l/down_l/up_r/down_r: paddle buttons (level, sampled on tick)
//   pixel                  : paddle or ball at (x,y), one cycle after x/y
//   rgb                    : background colour for the current game state
//   score_l, score_r       : scores
//   state                  : game FSM state encoding
// ---------------------------------------------------------------------------
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned PADDLE_X_L   = 16,
    parameter int unsigned PADDLE_X_R   = 616,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PADDLE_SPEED = 4,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs_in,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        start,
    input  logic        up_l,
    input  logic        down_l,
    input  logic        up_r,
    input  logic        down_r,
    output logic        pixel,
    output logic [11:0] rgb,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  state
);

    localparam logic [10:0] SW   = 11'(SCREEN_W);
    localparam logic [10:0] SH   = 11'(SCREEN_H);
    localparam logic [10:0] PW   = 11'(PADDLE_W);
    localparam logic [10:0] PH   = 11'(PADDLE_H);
    localparam logic [10:0] PXL  = 11'(PADDLE_X_L);
    localparam logic [10:0] PXR  = 11'(PADDLE_X_R);
    localparam logic [10:0] BSZ  = 11'(BALL_SIZE);
    localparam logic [10:0] PSPD = 11'(PADDLE_SPEED);
    localparam logic [10:0] BSPD = 11'(BALL_SPEED);
    localparam logic [10:0] PMAX = 11'(SCREEN_H - PADDLE_H);
    localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE_LD = 8'(SERVE_FRAMES);
    localparam logic [7:0]  POINT_LD = 8'(POINT_FRAMES);

    logic tick;

    vsync_tick u_vsync_tick (
        .clk   (clk),
        .rst   (rst),
        .vs_in (vs_in),
        .tick  (tick)
    );

    state_t      state_q,   state_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic [9:0]  pl_y_q,    pl_y_d;
    logic [9:0]  pr_y_q,    pr_y_d;
    logic [9:0]  bx_q,      bx_d;
    logic [9:0]  by_q,      by_d;
    logic        dx_q,      dx_d;      // 1 = moving right
    logic        dy_q,      dy_d;      // 1 = moving down
    logic        serve_q,   serve_d;   // 1 = serve to the right
    logic [7:0]  cnt_q,     cnt_d;
    logic        pixel_q,   pixel_d;
    logic [11:0] rgb_q,     rgb_d;

    function automatic logic [9:0] paddle_step(input logic [9:0] py,
                                               input logic up, input logic dn);
        logic [10:0] p;
        p = {1'b0, py};
        if (up && !dn) begin
            p = (p < PSPD) ? '0 : p - PSPD;
        end else if (dn && !up) begin
            p = (p + PSPD > PMAX) ? PMAX : p + PSPD;
        end
        return 10'(p);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    logic [10:0] bx_w, by_w, pl_w, pr_w;
    logic [9:0]  pl_next, pr_next, bx_move, by_move;
    logic        dx_move, dy_move;
    logic        overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;

    always_comb begin
        bx_w = {1'b0, bx_q};
        by_w = {1'b0, by_q};
        pl_w = {1'b0, pl_y_q};
        pr_w = {1'b0, pr_y_q};

        pl_next = paddle_step(pl_y_q, up_l, down_l);
        pr_next = paddle_step(pr_y_q, up_r, down_r);

        // Y axis: walls clamp the ball flush and flip direction
        if (!dy_q) begin
            if (by_w < BSPD) begin
                by_move = '0;
                dy_move = 1'b1;
            end else begin
                by_move = 10'(by_w - BSPD);
                dy_move = 1'b0;
            end
        end else if (by_w + BSZ + BSPD > SH) begin
            by_move = 10'(SH - BSZ);
            dy_move = 1'b0;
        end else begin
            by_move = 10'(by_w + BSPD);
            dy_move = 1'b1;
        end

        // X axis uses the pre-update paddle and ball rows
        overlap_l = (by_w + BSZ > pl_w) && (by_w < pl_w + PH);
        overlap_r = (by_w + BSZ > pr_w) && (by_w < pr_w + PH);
        hit_l  = !dx_q && (bx_w >= PXL + PW) && (bx_w - BSPD < PXL + PW) && overlap_l;
        hit_r  =  dx_q && (bx_w + BSZ <= PXR) && (bx_w + BSZ + BSPD > PXR) && overlap_r;
        miss_l = !dx_q && !hit_l && (bx_w < BSPD);
        miss_r =  dx_q && !hit_r && (bx_w + BSZ + BSPD > SW);

        if (hit_l) begin
            bx_move = 10'(PXL + PW);
            dx_move = 1'b1;
        end else if (hit_r) begin
            bx_move = 10'(PXR - BSZ);
            dx_move = 1'b0;
        end else begin
            bx_move = dx_q ? 10'(bx_w + BSPD) : 10'(bx_w - BSPD);
            dx_move = dx_q;
        end

        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        pl_y_d    = pl_y_q;
        pr_y_d    = pr_y_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        serve_d   = serve_q;
        cnt_d     = cnt_q;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SERVE;
                        cnt_d   = SERVE_LD;
                    end
                end
                ST_SERVE: begin
                    pl_y_d = pl_next;
                    pr_y_d = pr_next;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_PLAY;
                        dx_d    = serve_q;
                        dy_d    = 1'b1;
                    end
                end
                ST_PLAY: begin
                    pl_y_d = pl_next;
                    pr_y_d = pr_next;
                    bx_d   = bx_move;
                    by_d   = by_move;
                    dx_d   = dx_move;
                    dy_d   = dy_move;
                    // Serve goes back toward whoever conceded
                    if (miss_l || miss_r) begin
                        if (miss_l) score_r_d = sat_inc(score_r_q);
                        else        score_l_d = sat_inc(score_l_q);
                        serve_d = miss_r;
                        bx_d    = BALL_X0;
                        by_d    = BALL_Y0;
                        state_d = ST_POINT;
                        cnt_d   = POINT_LD;
                    end
                end
                ST_POINT: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        if (score_l_q == WIN || score_r_q == WIN) begin
                            state_d = ST_GAMEOVER;
                        end else begin
                            state_d = ST_SERVE;
                            cnt_d   = SERVE_LD;
                        end
                    end
                end
                ST_GAMEOVER: begin
                    if (start) begin
                        score_l_d = '0;
                        score_r_d = '0;
                        state_d   = ST_SERVE;
                        cnt_d     = SERVE_LD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        pixel_d = in_rect({1'b0, x}, {1'b0, y}, PXL, pl_w, PW, PH)
                | in_rect({1'b0, x}, {1'b0, y}, PXR, pr_w, PW, PH)
                | in_rect({1'b0, x}, {1'b0, y}, bx_w, by_w, BSZ, BSZ);
        rgb_d   = state_rgb(state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            score_l_q <= '0;
            score_r_q <= '0;
            pl_y_q    <= PADDLE_Y0;
            pr_y_q    <= PADDLE_Y0;
            bx_q      <= BALL_X0;
            by_q      <= BALL_Y0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            serve_q   <= 1'b1;
            cnt_q     <= '0;
            pixel_q   <= 1'b0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            pl_y_q    <= pl_y_d;
            pr_y_q    <= pr_y_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            serve_q   <= serve_d;
            cnt_q     <= cnt_d;
            pixel_q   <= pixel_d;
            rgb_q     <= rgb_d;
        end
    end

    assign pixel   = pixel_q;
    assign rgb     = rgb_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs_in;
    logic [9:0]  x, y;
    logic        start, up_l, down_l, up_r, down_r;
    logic        pixel;
    logic [11:0] rgb;
    logic [3:0]  score_l, score_r;
    logic [2:0]  state;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk(clk), .rst(rst), .vs_in(vs_in), .x(x), .y(y),
        .start(start), .up_l(up_l), .down_l(down_l), .up_r(up_r), .down_r(down_r),
        .pixel(pixel), .rgb(rgb), .score_l(score_l), .score_r(score_r), .state(state)
    );

    int errors = 0;
    int checks = 0;

    // Reference game model: states 0 idle,1 serve,2 play,3 point,4 game over
    int m_state, m_sl, m_sr, m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_serve, m_cnt;

    task automatic model_reset();
        m_state = 0; m_sl = 0; m_sr = 0; m_pl = 208; m_pr = 208;
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_serve = 1; m_cnt = 0;
    endtask

    function automatic int pmove(int p, bit up, bit dn);
        if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
        if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
        return p;
    endfunction

    function automatic bit overlaps(int ball_y, int pad_y);
        return (ball_y + 8 > pad_y) && (ball_y < pad_y + 64);
    endfunction

    task automatic model_tick(input bit st, input bit ul, input bit dl, input bit ur, input bit dr);
        int old_pl, old_pr, scorer;
        old_pl = m_pl; old_pr = m_pr; scorer = 0;
        case (m_state)
            0: if (st) begin m_state = 1; m_cnt = 60; end
            1: begin
                m_pl = pmove(m_pl, ul, dl); m_pr = pmove(m_pr, ur, dr);
                m_cnt--;
                if (m_cnt == 0) begin m_state = 2; m_dx = m_serve; m_dy = 1; end
            end
            2: begin
                m_pl = pmove(m_pl, ul, dl); m_pr = pmove(m_pr, ur, dr);
                if (m_dx > 0) begin
                    if (m_bx + 8 <= 616 && m_bx + 10 > 616 && overlaps(m_by, old_pr)) begin
                        m_bx = 608; m_dx = -1;
                    end else if (m_bx + 10 > 640) scorer = -1;
                    else m_bx += 2;
                end else begin
                    if (m_bx >= 24 && m_bx - 2 < 24 && overlaps(m_by, old_pl)) begin
                        m_bx = 24; m_dx = 1;
                    end else if (m_bx < 2) scorer = 1;
                    else m_bx -= 2;
                end
                if (m_dy < 0) begin
                    if (m_by < 2) begin m_by = 0; m_dy = 1; end else m_by -= 2;
                end else begin
                    if (m_by + 10 > 480) begin m_by = 472; m_dy = -1; end else m_by += 2;
                end
                if (scorer != 0) begin
                    if (scorer < 0) begin m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_serve = 1; end
                    else            begin m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_serve = -1; end
                    m_bx = 316; m_by = 236; m_state = 3; m_cnt = 30;
                end
            end
            3: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_sl == 9 || m_sr == 9) m_state = 4;
                    else begin m_state = 1; m_cnt = 60; end
                end
            end
            4: if (st) begin m_sl = 0; m_sr = 0; m_state = 1; m_cnt = 60; end
            default: ;
        endcase
    endtask

    function automatic bit inside_box(int px, int py, int l, int t, int w, int h);
        return px >= l && px < l + w && py >= t && py < t + h;
    endfunction

    function automatic bit model_pixel(int px, int py);
        return inside_box(px, py, 16, m_pl, 8, 64) || inside_box(px, py, 616, m_pr, 8, 64)
            || inside_box(px, py, m_bx, m_by, 8, 8);
    endfunction

    function automatic int model_rgb();
        case (m_state)
            0: return 'h004;
            3: return 'h400;
            4: return 'h040;
            default: return 'h000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag, input int px, input int py);
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        x = 10'(px);
        y = 10'(py);
        step();
        check(tag, 32'(pixel), 32'(model_pixel(px, py)));
    endtask

    // One video frame: VS low 3 cycles, then the state update and checks
    task automatic frame(input bit st, input bit ul, input bit dl, input bit ur, input bit dr);
        start = st; up_l = ul; down_l = dl; up_r = ur; down_r = dr;
        vs_in = 1'b0;
        repeat (3) step();
        vs_in = 1'b1;
        step();
        model_tick(st, ul, dl, ur, dr);
        step();
        check("state", 32'(state), 32'(m_state));
        check("score_l", 32'(score_l), 32'(m_sl));
        check("score_r", 32'(score_r), 32'(m_sr));
        check("rgb", 32'(rgb), 32'(model_rgb()));
        probe("ball_corner", m_bx, m_by);
        probe("near_ball", m_bx - 4 + int'($urandom_range(0, 15)), m_by - 4 + int'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 0)
            probe("near_pad_l", 14 + int'($urandom_range(0, 11)), m_pl - 4 + int'($urandom_range(0, 71)));
        else
            probe("near_pad_r", 614 + int'($urandom_range(0, 11)), m_pr - 4 + int'($urandom_range(0, 71)));
    endtask

    initial begin
        bit ul, dl, ur, dr;
        int frames;

        rst = 1'b1; vs_in = 1'b1; x = 10'd16; y = 10'd208;
        start = 0; up_l = 0; down_l = 0; up_r = 0; down_r = 0;
        model_reset();
        step(); step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_score_l", 32'(score_l), 32'd0);
        check("rst_score_r", 32'(score_r), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_rgb", 32'(rgb), 32'h000);
        rst = 1'b0;
        step();
        check("raster_16_208", 32'(pixel), 32'd1);
        check("idle_rgb", 32'(rgb), 32'h004);
        x = 10'd24; step();
        check("raster_24_208", 32'(pixel), 32'd0);
        x = 10'd316; y = 10'd236; step();
        check("raster_316_236", 32'(pixel), 32'd1);
        step();

        frame(0, 0, 0, 0, 0);
        check("idle_no_start", 32'(state), 32'd0);
        frame(1, 0, 0, 0, 0);
        check("idle_to_serve", 32'(state), 32'd1);

        for (int i = 0; i < 60; i++)
            frame(0, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("serve_to_play", 32'(state), 32'd2);
        probe("pad_l_top_clamp", 16, 0);
        probe("pad_l_top_end", 16, 64);

        frame(0, 0, 0, 0, 0);
        probe("ball_318_238", 318, 238);
        probe("ball_317_238", 317, 238);

        frames = 0;
        while (m_state != 4 && frames < 5000) begin
            if (frames < 120) begin
                ul = 0; dl = 1;
            end else if ($urandom_range(0, 7) == 0) begin
                ul = 1'($urandom_range(0, 1)); dl = 1'($urandom_range(0, 1));
            end else begin
                ul = (m_by + 4 < m_pl + 28);
                dl = (m_by + 4 > m_pl + 36);
            end
            if ($urandom_range(0, 3) == 0) begin
                ur = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
            end else begin
                dr = (m_by + 4 < m_pr + 32);
                ur = !dr;
            end
            frame(0, ul, dl, ur, dr);
            if (frames == 120) begin
                probe("pad_l_bot_clamp", 16, 479);
                probe("pad_l_bot_edge", 16, 415);
                frame(0, 1, 1, 0, 0);
                frame(0, 1, 1, 0, 0);
                probe("pad_l_both_hold", 16, m_pl);
                probe("pad_l_both_above", 16, m_pl - 1);
            end
            frames++;
        end
        check("gameover_reached", 32'(state), 32'd4);
        check("gameover_rgb", 32'(rgb), 32'h040);

        frame(1, 0, 0, 0, 0);
        check("restart_state", 32'(state), 32'd1);
        check("restart_score_l", 32'(score_l), 32'd0);
        check("restart_score_r", 32'(score_r), 32'd0);

        for (int i = 0; i < 65; i++)
            frame(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("midplay_state", 32'(state), 32'd2);

        x = 10'd316; y = 10'd236;
        rst = 1'b1;
        step();
        model_reset();
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_score_l", 32'(score_l), 32'd0);
        check("midrst_score_r", 32'(score_r), 32'd0);
        check("midrst_pixel", 32'(pixel), 32'd0);
        check("midrst_rgb", 32'(rgb), 32'h000);
        rst = 1'b0;
        probe("midrst_ball", 316, 236);
        probe("midrst_pad_l", 16, 208);
        probe("midrst_pad_r", 623, 271);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
